branch_ctrl: RTL and testbench

Parametrised branch controller for the single-cycle core. It evaluates branch, loop and call/return instructions and produces the taken decision and target address in the same cycle. Compared with the earlier fixed flag-register branch unit, it adds:
- a bank of selectable flag contexts;
- a hardware loop counter;
- a return-address stack with overflow/underflow tracking.

It sits between decode and the program counter: `branch`/`address` feed the next-PC mux.

---
 rtl/branch_pkg.sv | 36 +++
 rtl/branch_ctrl_if.sv | 59 +++++
 rtl/branch_ctrl_link_stack.sv | 124 ++++++++++++
 rtl/branch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_branch_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch controller:
//   - FLAG_* : bit positions of the mode bits inside a flag context
//   - flag_t : packed view of one flag context {loop, alw, lt, eq}
//   - instr_kind_e : instruction kind after priority resolution
//   - sel_width() : select-field width for a bank of n entries (min 1 bit)
// ---------------------------------------------------------------------------
package branch_pkg;

  localparam int FLAG_EQ   = 0;
  localparam int FLAG_LT   = 1;
  localparam int FLAG_ALW  = 2;
  localparam int FLAG_LOOP = 3;

  typedef struct packed {
    logic loop;
    logic alw;
    logic lt;
    logic eq;
  } flag_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BR   = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } instr_kind_e;

  // A bank with a single entry still gets a 1-bit select so ports never
  // collapse to zero width.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_ctrl_if
// Decode-side bus of the branch controller.
//   master (decode/fetch): drives flag writes, compare results, instruction
//     strobes, immediate, return_pc and loop-counter load.
//   slave (branch_ctrl): drives address/branch to the next-PC mux plus
//     loop_count and the return-stack status flags.
// ---------------------------------------------------------------------------
interface branch_ctrl_if
  import branch_pkg::*;
#(
  parameter int IMM_W   = 6,
  parameter int ADDR_W  = 10,
  parameter int NUM_CTX = 4,
  parameter int LOOP_W  = 8
);

  localparam int CTX_W = sel_width(NUM_CTX);

  // decode -> controller
  logic              w_flag;
  logic [3:0]        flag_in;
  logic [CTX_W-1:0]  ctx_sel;
  logic              equal;
  logic              less;
  logic              branch_instr;
  logic              call_instr;
  logic              ret_instr;
  logic [IMM_W-1:0]  immediate;
  logic [ADDR_W-1:0] return_pc;
  logic              loop_load;
  logic [LOOP_W-1:0] loop_value;

  // controller -> next-PC mux / status
  logic [ADDR_W-1:0] address;
  logic              branch;
  logic [LOOP_W-1:0] loop_count;
  logic              stack_empty;
  logic              stack_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output w_flag, flag_in, ctx_sel, equal, less,
           branch_instr, call_instr, ret_instr,
           immediate, return_pc, loop_load, loop_value,
    input  address, branch, loop_count,
           stack_empty, stack_full, overflow, underflow
  );

  modport slave (
    input  w_flag, flag_in, ctx_sel, equal, less,
           branch_instr, call_instr, ret_instr,
           immediate, return_pc, loop_load, loop_value,
    output address, branch, loop_count,
           stack_empty, stack_full, overflow, underflow
  );

endinterface

// File: rtl/branch_ctrl_link_stack.sv
// ---------------------------------------------------------------------------
// link_stack
// Return-address LIFO held as a circular buffer so that a push on a full
// stack silently drops the oldest entry.
// Ports:
//   clk, reset     : clock, synchronous active-low reset
//   push/push_data : push an address at the edge
//   pop            : pop the top entry at the edge (wins over push)
//   top_data       : current top entry (combinational read)
//   empty/full     : registered occupancy status
//   overflow       : sticky, set by a push while full
//   underflow      : sticky, set by a pop while empty
// ---------------------------------------------------------------------------
module link_stack #(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(STACK_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(STACK_DEPTH);

  if (STACK_DEPTH < 2) begin : g_chk_depth
    $error("link_stack: STACK_DEPTH must be at least 2");
  end

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [ADDR_W-1:0] mem_d [STACK_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;   // next free slot
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [PTR_W-1:0]  top_idx_s;
  logic [PTR_W-1:0]  next_idx_s;

  // Ring-buffer neighbours of the write pointer (depth need not be a power of 2).
  always_comb begin
    if (wr_ptr_q == '0) begin
      top_idx_s = LAST_IDX;
    end else begin
      top_idx_s = wr_ptr_q - PTR_W'(1);
    end
    if (wr_ptr_q == LAST_IDX) begin
      next_idx_s = '0;
    end else begin
      next_idx_s = wr_ptr_q + PTR_W'(1);
    end
  end

  assign top_data = mem_q[top_idx_s];

  // Next-state for storage, pointer, occupancy and sticky errors.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (pop) begin
      if (!empty_q) begin
        wr_ptr_d = top_idx_s;
        cnt_d    = cnt_q - CNT_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_idx_s;
      // When full the write lands on the oldest slot, so depth stays put.
      if (full_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == DEPTH_C);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
// Same-cycle branch/loop/call/return resolution for the single-cycle core.
// Ports:
//   clk   : clock
//   reset : synchronous active-low reset
//   bus   : branch_ctrl_if slave -- decode inputs in, branch/address to the
//           next-PC mux, loop_count and return-stack status out.
// branch/address are combinational from the inputs and current state; all
// other outputs come straight from registers.
// ---------------------------------------------------------------------------
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int IMM_W       = 6,
  parameter int SHIFT       = 3,
  parameter int ADDR_W      = 10,
  parameter int NUM_CTX     = 4,
  parameter int LOOP_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  branch_ctrl_if.slave bus
);

  localparam int CTX_W = sel_width(NUM_CTX);

  if (ADDR_W < IMM_W + SHIFT) begin : g_chk_addr
    $error("branch_ctrl: ADDR_W must be >= IMM_W + SHIFT");
  end
  if (NUM_CTX < 1) begin : g_chk_ctx
    $error("branch_ctrl: NUM_CTX must be at least 1");
  end

  flag_t             ctx_q [NUM_CTX];
  flag_t             ctx_d [NUM_CTX];
  logic [LOOP_W-1:0] loop_q, loop_d;

  flag_t             cur_flag_s;
  logic [3:0]        cur_bits_s;
  instr_kind_e       kind_s;
  logic [ADDR_W-1:0] imm_tgt_s;
  logic [ADDR_W-1:0] tgt_s;
  logic              br_s;
  logic              push_s;
  logic              pop_s;
  logic              dec_s;
  logic              loop_nz_s;
  logic [ADDR_W-1:0] top_data_s;
  logic              stk_empty_s;

  // Read the selected context (pre-write value); unmapped selects read as 0.
  always_comb begin
    cur_flag_s = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (bus.ctx_sel == CTX_W'(i)) begin
        cur_flag_s = ctx_q[i];
      end else begin
        cur_flag_s = cur_flag_s;
      end
    end
  end

  assign cur_bits_s = cur_flag_s;
  assign loop_nz_s  = (loop_q != '0);
  assign imm_tgt_s  = ADDR_W'(bus.immediate) << SHIFT;

  // Priority resolve: ret > call > branch.
  always_comb begin
    if (bus.ret_instr) begin
      kind_s = RET;
    end else if (bus.call_instr) begin
      kind_s = CALL;
    end else if (bus.branch_instr) begin
      kind_s = BR;
    end else begin
      kind_s = NONE;
    end
  end

  // Decision, target mux and side-effect strobes for the resolved kind.
  always_comb begin
    br_s   = 1'b0;
    tgt_s  = imm_tgt_s;
    push_s = 1'b0;
    pop_s  = 1'b0;
    dec_s  = 1'b0;
    case (kind_s)
      RET: begin
        // An empty-stack pop only raises underflow inside the stack.
        pop_s = 1'b1;
        if (!stk_empty_s) begin
          br_s  = 1'b1;
          tgt_s = top_data_s;
        end else begin
          br_s  = 1'b0;
          tgt_s = imm_tgt_s;
        end
      end
      CALL: begin
        br_s   = 1'b1;
        push_s = 1'b1;
      end
      BR: begin
        br_s  = cur_bits_s[FLAG_ALW]
              | (cur_bits_s[FLAG_LT]   & bus.less)
              | (cur_bits_s[FLAG_EQ]   & bus.equal)
              | (cur_bits_s[FLAG_LOOP] & loop_nz_s);
        // Counter saturates at zero instead of wrapping.
        dec_s = cur_bits_s[FLAG_LOOP] & loop_nz_s;
      end
      NONE: begin
        br_s = 1'b0;
      end
      default: begin
        br_s = 1'b0;
      end
    endcase
  end

  // Context bank write.
  always_comb begin
    ctx_d = ctx_q;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (bus.w_flag && (bus.ctx_sel == CTX_W'(i))) begin
        ctx_d[i] = flag_t'(bus.flag_in);
      end else begin
        ctx_d[i] = ctx_q[i];
      end
    end
  end

  // Loop counter: a load beats a same-cycle decrement.
  always_comb begin
    if (bus.loop_load) begin
      loop_d = bus.loop_value;
    end else if (dec_s) begin
      loop_d = loop_q - LOOP_W'(1);
    end else begin
      loop_d = loop_q;
    end
  end

  // Context bank and loop counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        ctx_q[i] <= '0;
      end
      loop_q <= '0;
    end else begin
      ctx_q  <= ctx_d;
      loop_q <= loop_d;
    end
  end

  link_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_link_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (bus.return_pc),
    .top_data  (top_data_s),
    .empty     (stk_empty_s),
    .full      (bus.stack_full),
    .overflow  (bus.overflow),
    .underflow (bus.underflow)
  );

  assign bus.branch      = br_s;
  assign bus.address     = tgt_s;
  assign bus.loop_count  = loop_q;
  assign bus.stack_empty = stk_empty_s;

endmodule

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl
// Directed scenarios followed by randomized traffic checked against a
// behavioural model (queue-based return stack, integer loop counter).
// ---------------------------------------------------------------------------
module tb_branch_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  branch_ctrl_if #(.IMM_W(6), .ADDR_W(10), .NUM_CTX(4), .LOOP_W(8)) bus ();

  branch_ctrl #(
    .IMM_W(6), .SHIFT(3), .ADDR_W(10), .NUM_CTX(4), .LOOP_W(8), .STACK_DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- behavioural model ----------------
  logic [3:0] m_ctx [4];
  int         m_loop;
  logic [9:0] m_stk [$];
  bit         m_ovf;
  bit         m_unf;

  task automatic model_expect(output logic eb, output logic [9:0] ea);
    logic [3:0] f;
    logic [9:0] dflt;
    f    = m_ctx[bus.ctx_sel];
    dflt = 10'(bus.immediate) * 10'd8;
    eb   = 1'b0;
    ea   = dflt;
    if (bus.ret_instr) begin
      if (m_stk.size() > 0) begin eb = 1'b1; ea = m_stk[$]; end
    end else if (bus.call_instr) begin
      eb = 1'b1;
    end else if (bus.branch_instr) begin
      eb = f[2] | (f[1] & bus.less) | (f[0] & bus.equal) | (f[3] & (m_loop != 0));
    end
  endtask

  task automatic model_step();
    logic [3:0] f;
    bit dec;
    f   = m_ctx[bus.ctx_sel];
    dec = 1'b0;
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_ctx[i] = 4'd0;
      m_loop = 0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (bus.ret_instr) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_unf = 1'b1;
      end else if (bus.call_instr) begin
        m_stk.push_back(bus.return_pc);
        if (m_stk.size() > 4) begin void'(m_stk.pop_front()); m_ovf = 1'b1; end
      end else if (bus.branch_instr) begin
        dec = f[3] && (m_loop != 0);
      end
      if (bus.w_flag) m_ctx[bus.ctx_sel] = bus.flag_in;
      if (bus.loop_load) m_loop = int'(bus.loop_value);
      else if (dec) m_loop = m_loop - 1;
    end
  endtask

  // Advance one clock: model consumes the current inputs, DUT takes the edge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b1;
    bus.w_flag = 1'b0; bus.flag_in = 4'd0; bus.ctx_sel = 2'd0;
    bus.equal = 1'b0; bus.less = 1'b0;
    bus.branch_instr = 1'b0; bus.call_instr = 1'b0; bus.ret_instr = 1'b0;
    bus.immediate = 6'd0; bus.return_pc = 10'd0;
    bus.loop_load = 1'b0; bus.loop_value = 8'd0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); reset = 1'b0;
    step(); step();
    idle(); #1;
    n_tests++; if (bus.branch !== 1'b0) begin n_fail++; $display("FAIL reset_branch got=%b exp=0", bus.branch); end
    n_tests++; if (bus.address !== 10'h000) begin n_fail++; $display("FAIL reset_address got=%h exp=000", bus.address); end
    n_tests++; if (bus.loop_count !== 8'd0) begin n_fail++; $display("FAIL reset_loop got=%0d exp=0", bus.loop_count); end
    n_tests++; if (bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin n_fail++; $display("FAIL reset_stack got empty=%b full=%b exp 1/0", bus.stack_empty, bus.stack_full); end
    n_tests++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got ovf=%b unf=%b exp 0/0", bus.overflow, bus.underflow); end
    bus.w_flag = 1'b1; bus.flag_in = 4'b0100; bus.ctx_sel = 2'd0;
    step();
    idle(); bus.branch_instr = 1'b1; bus.immediate = 6'h05; #1;
    n_tests++; if (bus.branch !== 1'b1) begin n_fail++; $display("FAIL always_branch got=%b exp=1", bus.branch); end
    n_tests++; if (bus.address !== 10'h028) begin n_fail++; $display("FAIL always_address got=%h exp=028", bus.address); end
    step();
  endtask

  task automatic test_context();
    idle(); bus.w_flag = 1'b1; bus.ctx_sel = 2'd1; bus.flag_in = 4'b0001; step();
    idle(); bus.w_flag = 1'b1; bus.ctx_sel = 2'd2; bus.flag_in = 4'b0010; step();
    idle(); bus.branch_instr = 1'b1; bus.equal = 1'b1; bus.ctx_sel = 2'd1; #1;
    n_tests++; if (bus.branch !== 1'b1) begin n_fail++; $display("FAIL ctx1_equal got=%b exp=1", bus.branch); end
    bus.ctx_sel = 2'd2; #1;
    n_tests++; if (bus.branch !== 1'b0) begin n_fail++; $display("FAIL ctx2_equal got=%b exp=0", bus.branch); end
    bus.w_flag = 1'b1; bus.flag_in = 4'b0100; #1;
    n_tests++; if (bus.branch !== 1'b0) begin n_fail++; $display("FAIL ctx_write_same_cycle got=%b exp=0", bus.branch); end
    step();
    idle(); bus.branch_instr = 1'b1; bus.ctx_sel = 2'd2; #1;
    n_tests++; if (bus.branch !== 1'b1) begin n_fail++; $display("FAIL ctx_write_next_cycle got=%b exp=1", bus.branch); end
    step();
  endtask

  task automatic test_loop();
    idle(); bus.w_flag = 1'b1; bus.ctx_sel = 2'd3; bus.flag_in = 4'b1000; step();
    idle(); bus.loop_load = 1'b1; bus.loop_value = 8'd3; step();
    idle(); #1;
    n_tests++; if (bus.loop_count !== 8'd3) begin n_fail++; $display("FAIL loop_load got=%0d exp=3", bus.loop_count); end
    for (int i = 0; i < 4; i++) begin
      idle(); bus.branch_instr = 1'b1; bus.ctx_sel = 2'd3; #1;
      n_tests++; if (bus.branch !== ((i < 3) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL loop_branch[%0d] got=%b exp=%b", i, bus.branch, (i < 3)); end
      step(); #1;
      n_tests++; if (int'(bus.loop_count) !== ((i < 3) ? 2 - i : 0)) begin n_fail++; $display("FAIL loop_count[%0d] got=%0d exp=%0d", i, bus.loop_count, (i < 3) ? 2 - i : 0); end
    end
    idle(); bus.loop_load = 1'b1; bus.loop_value = 8'd2; step();
    idle(); bus.branch_instr = 1'b1; bus.ctx_sel = 2'd3; bus.loop_load = 1'b1; bus.loop_value = 8'd9; #1;
    n_tests++; if (bus.branch !== 1'b1) begin n_fail++; $display("FAIL load_branch got=%b exp=1", bus.branch); end
    step(); #1;
    n_tests++; if (bus.loop_count !== 8'd9) begin n_fail++; $display("FAIL load_wins got=%0d exp=9", bus.loop_count); end
  endtask

  task automatic test_call_ret();
    idle(); bus.call_instr = 1'b1; bus.immediate = 6'h0A; bus.return_pc = 10'h011; #1;
    n_tests++; if (bus.branch !== 1'b1 || bus.address !== 10'h050) begin n_fail++; $display("FAIL call_target got br=%b addr=%h exp 1/050", bus.branch, bus.address); end
    step();
    idle(); bus.call_instr = 1'b1; bus.return_pc = 10'h022; step();
    idle(); bus.ret_instr = 1'b1; #1;
    n_tests++; if (bus.branch !== 1'b1 || bus.address !== 10'h022) begin n_fail++; $display("FAIL ret1 got br=%b addr=%h exp 1/022", bus.branch, bus.address); end
    step(); #1;
    n_tests++; if (bus.branch !== 1'b1 || bus.address !== 10'h011) begin n_fail++; $display("FAIL ret2 got br=%b addr=%h exp 1/011", bus.branch, bus.address); end
    step();
    bus.immediate = 6'h03; #1;
    n_tests++; if (bus.branch !== 1'b0 || bus.address !== 10'h018) begin n_fail++; $display("FAIL ret_empty got br=%b addr=%h exp 0/018", bus.branch, bus.address); end
    step(); idle(); #1;
    n_tests++; if (bus.underflow !== 1'b1 || bus.stack_empty !== 1'b1) begin n_fail++; $display("FAIL underflow got unf=%b empty=%b exp 1/1", bus.underflow, bus.stack_empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      idle(); bus.call_instr = 1'b1; bus.return_pc = 10'h100 + 10'(i); step();
    end
    idle(); #1;
    n_tests++; if (bus.overflow !== 1'b1 || bus.stack_full !== 1'b1) begin n_fail++; $display("FAIL overflow got ovf=%b full=%b exp 1/1", bus.overflow, bus.stack_full); end
    for (int i = 0; i < 4; i++) begin
      idle(); bus.ret_instr = 1'b1; #1;
      n_tests++; if (bus.branch !== 1'b1 || bus.address !== 10'h104 - 10'(i)) begin n_fail++; $display("FAIL ovf_ret[%0d] got br=%b addr=%h exp 1/%h", i, bus.branch, bus.address, 10'h104 - 10'(i)); end
      step();
    end
    idle(); #1;
    n_tests++; if (bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got empty=%b full=%b exp 1/0", bus.stack_empty, bus.stack_full); end
  endtask

  task automatic test_priority_reset();
    idle(); bus.call_instr = 1'b1; bus.return_pc = 10'h155; step();
    idle(); bus.call_instr = 1'b1; bus.ret_instr = 1'b1; bus.immediate = 6'h01; bus.return_pc = 10'h0AA; #1;
    n_tests++; if (bus.branch !== 1'b1 || bus.address !== 10'h155) begin n_fail++; $display("FAIL call_ret_prio got br=%b addr=%h exp 1/155", bus.branch, bus.address); end
    step(); idle(); #1;
    n_tests++; if (bus.stack_empty !== 1'b1) begin n_fail++; $display("FAIL call_ret_no_push got empty=%b exp 1", bus.stack_empty); end
    idle(); bus.loop_load = 1'b1; bus.loop_value = 8'd4; step();
    idle(); bus.call_instr = 1'b1; bus.return_pc = 10'h033; step();
    idle(); reset = 1'b0; bus.branch_instr = 1'b1; bus.ctx_sel = 2'd3; bus.loop_load = 1'b1; bus.loop_value = 8'd7;
    step();
    idle(); #1;
    n_tests++; if (bus.loop_count !== 8'd0 || bus.stack_empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset got loop=%0d empty=%b exp 0/1", bus.loop_count, bus.stack_empty); end
    n_tests++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sticky got ovf=%b unf=%b exp 0/0", bus.overflow, bus.underflow); end
    bus.branch_instr = 1'b1; bus.ctx_sel = 2'd0; #1;
    n_tests++; if (bus.branch !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctx got=%b exp=0", bus.branch); end
    step();
  endtask

  task automatic test_random();
    logic       eb;
    logic [9:0] ea;
    for (int n = 0; n < 400; n++) begin
      idle();
      reset            = ($urandom_range(0, 39) != 0);
      bus.w_flag       = ($urandom_range(0, 3) == 0);
      bus.flag_in      = 4'($urandom);
      bus.ctx_sel      = 2'($urandom);
      bus.equal        = 1'($urandom);
      bus.less         = 1'($urandom);
      bus.branch_instr = ($urandom_range(0, 1) == 0);
      bus.call_instr   = ($urandom_range(0, 3) == 0);
      bus.ret_instr    = ($urandom_range(0, 3) == 0);
      bus.immediate    = 6'($urandom);
      bus.return_pc    = 10'($urandom);
      bus.loop_load    = ($urandom_range(0, 7) == 0);
      bus.loop_value   = 8'($urandom_range(0, 6));
      #1;
      model_expect(eb, ea);
      n_tests++; if (bus.branch !== eb) begin n_fail++; $display("FAIL rnd_branch[%0d] got=%b exp=%b", n, bus.branch, eb); end
      n_tests++; if (bus.address !== ea) begin n_fail++; $display("FAIL rnd_address[%0d] got=%h exp=%h", n, bus.address, ea); end
      n_tests++; if (int'(bus.loop_count) !== m_loop) begin n_fail++; $display("FAIL rnd_loop[%0d] got=%0d exp=%0d", n, bus.loop_count, m_loop); end
      n_tests++; if (bus.stack_empty !== (m_stk.size() == 0) || bus.stack_full !== (m_stk.size() == 4)) begin n_fail++; $display("FAIL rnd_stack[%0d] got empty=%b full=%b depth=%0d", n, bus.stack_empty, bus.stack_full, m_stk.size()); end
      n_tests++; if (bus.overflow !== m_ovf || bus.underflow !== m_unf) begin n_fail++; $display("FAIL rnd_sticky[%0d] got ovf=%b unf=%b exp %b/%b", n, bus.overflow, bus.underflow, m_ovf, m_unf); end
      step();
    end
  endtask

  initial begin
    idle();
    for (int i = 0; i < 4; i++) m_ctx[i] = 4'd0;
    m_loop = 0; m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    test_reset();
    test_context();
    test_loop();
    test_call_ret();
    test_overflow();
    test_priority_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
